// File: rtl/register_file_mp.sv
// register_file_mp: multi-port integer register file with a busy scoreboard.
// Read ports are combinational. Two write ports commit on CLK; port B wins
// an address collision. Optional same-cycle write-to-read bypass.
// The busy scoreboard tracks outstanding producers for hazard detection.
module register_file_mp #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int REG_COUNT  = 32,
    parameter int NUM_RD     = 3,
    parameter int BYPASS     = 1,
    parameter int ZERO_REG   = 1
) (
    input  logic                         CLK,
    input  logic                         RST_N,
    input  logic [NUM_RD*ADDR_WIDTH-1:0] RA,
    output logic [NUM_RD*DATA_WIDTH-1:0] RD,
    output logic [NUM_RD-1:0]            RD_BUSY,
    input  logic                         WE_A,
    input  logic [ADDR_WIDTH-1:0]        WA_A,
    input  logic [DATA_WIDTH-1:0]        WD_A,
    input  logic                         WE_B,
    input  logic [ADDR_WIDTH-1:0]        WA_B,
    input  logic [DATA_WIDTH-1:0]        WD_B,
    input  logic                         RSV_EN,
    input  logic [ADDR_WIDTH-1:0]        RSV_ADDR,
    input  logic                         FLUSH
);

    // First writable register. With a hardwired x0 the register 0 flop is
    // never selected, so it stays at its reset value of zero.
    localparam int LO = (ZERO_REG != 0) ? 1 : 0;

    logic [DATA_WIDTH-1:0] regs [REG_COUNT];
    logic [REG_COUNT-1:0]  busy;
    logic [REG_COUNT-1:0]  busy_nxt;
    logic [REG_COUNT-1:0]  hit_a;
    logic [REG_COUNT-1:0]  hit_b;
    logic [REG_COUNT-1:0]  hit_rsv;
    logic                  wr_ok_a;
    logic                  wr_ok_b;

    // Decode write and reserve addresses into one-hot selects. Addresses that
    // are out of range or hit x0 produce no select. Everything is gated by
    // RST_N so nothing leaks to the outputs through the bypass path during reset.
    always_comb begin
        hit_a   = '0;
        hit_b   = '0;
        hit_rsv = '0;
        for (int r = LO; r < REG_COUNT; r++) begin
            hit_a[r]   = RST_N && WE_A   && (WA_A     == ADDR_WIDTH'(r));
            hit_b[r]   = RST_N && WE_B   && (WA_B     == ADDR_WIDTH'(r));
            hit_rsv[r] = RST_N && RSV_EN && (RSV_ADDR == ADDR_WIDTH'(r));
        end
        wr_ok_a = |hit_a;
        wr_ok_b = |hit_b;
    end

    // Scoreboard update. FLUSH is applied first, then write clears, then
    // reservations. The last step is a set, so a new producer wins over both.
    always_comb begin
        busy_nxt = busy;
        if (FLUSH) begin
            busy_nxt = '0;
        end
        busy_nxt = (busy_nxt & ~(hit_a | hit_b)) | hit_rsv;
    end

    // State registers: data commits with B over A, and the busy vector.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            busy <= '0;
            for (int r = 0; r < REG_COUNT; r++) begin
                regs[r] <= '0;
            end
        end else begin
            busy <= busy_nxt;
            for (int r = 0; r < REG_COUNT; r++) begin
                if (hit_b[r]) begin
                    regs[r] <= WD_B;
                end else if (hit_a[r]) begin
                    regs[r] <= WD_A;
                end
            end
        end
    end

    // Combinational read ports. Unimplemented addresses and x0 read as zero
    // and not busy. When bypass is enabled, a same-cycle valid write overrides
    // the stored value (B applied last so it takes precedence) and the port
    // reads not-busy.
    always_comb begin
        RD      = '0;
        RD_BUSY = '0;
        for (int p = 0; p < NUM_RD; p++) begin
            for (int r = LO; r < REG_COUNT; r++) begin
                if (RA[p*ADDR_WIDTH +: ADDR_WIDTH] == ADDR_WIDTH'(r)) begin
                    RD[p*DATA_WIDTH +: DATA_WIDTH] = regs[r];
                    RD_BUSY[p]                     = busy[r];
                end
            end
            if (BYPASS != 0) begin
                if (wr_ok_a && (RA[p*ADDR_WIDTH +: ADDR_WIDTH] == WA_A)) begin
                    RD[p*DATA_WIDTH +: DATA_WIDTH] = WD_A;
                    RD_BUSY[p]                     = 1'b0;
                end
                if (wr_ok_b && (RA[p*ADDR_WIDTH +: ADDR_WIDTH] == WA_B)) begin
                    RD[p*DATA_WIDTH +: DATA_WIDTH] = WD_B;
                    RD_BUSY[p]                     = 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_register_file_mp.sv
// Directed testbench for register_file_mp. It drives two instances from the
// same stimulus:
//   u_dut  - default build (bypass on, 32 registers)
//   u_dut2 - bypass off, 16 registers
// Inputs change just after the falling edge. Outputs are sampled 1 ns later,
// well away from the rising edge.
`timescale 1ns/1ps
module tb_register_file_mp;

    logic        clk;
    logic        rst_n;
    logic [14:0] ra;
    logic [95:0] rd;
    logic [95:0] rd2;
    logic [2:0]  rd_busy;
    logic [2:0]  rd_busy2;
    logic        we_a;
    logic [4:0]  wa_a;
    logic [31:0] wd_a;
    logic        we_b;
    logic [4:0]  wa_b;
    logic [31:0] wd_b;
    logic        rsv_en;
    logic [4:0]  rsv_addr;
    logic        flush;

    int checks;
    int errors;

    register_file_mp u_dut (
        .CLK(clk), .RST_N(rst_n), .RA(ra), .RD(rd), .RD_BUSY(rd_busy),
        .WE_A(we_a), .WA_A(wa_a), .WD_A(wd_a),
        .WE_B(we_b), .WA_B(wa_b), .WD_B(wd_b),
        .RSV_EN(rsv_en), .RSV_ADDR(rsv_addr), .FLUSH(flush)
    );

    register_file_mp #(.REG_COUNT(16), .BYPASS(0)) u_dut2 (
        .CLK(clk), .RST_N(rst_n), .RA(ra), .RD(rd2), .RD_BUSY(rd_busy2),
        .WE_A(we_a), .WA_A(wa_a), .WD_A(wd_a),
        .WE_B(we_b), .WA_B(wa_b), .WD_B(wd_b),
        .RSV_EN(rsv_en), .RSV_ADDR(rsv_addr), .FLUSH(flush)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle();
        we_a = 1'b0; wa_a = '0; wd_a = '0;
        we_b = 1'b0; wa_b = '0; wd_b = '0;
        rsv_en = 1'b0; rsv_addr = '0; flush = 1'b0;
    endtask

    task automatic set_ra(input logic [4:0] a0, input logic [4:0] a1, input logic [4:0] a2);
        ra = {a2, a1, a0};
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle();
        we_a = 1'b1; wa_a = 5'd1; wd_a = 32'hFF;
        set_ra(5'd1, 5'd0, 5'd0);
        #1;
        checks++; if (rd !== 96'h0) begin errors++; $display("FAIL rst_rd: got %h exp 0", rd); end
        checks++; if (rd_busy !== 3'b000) begin errors++; $display("FAIL rst_busy: got %b exp 000", rd_busy); end
        @(negedge clk);
        #1;
        checks++; if (rd[31:0] !== 32'h0) begin errors++; $display("FAIL rst_wr_ignored: got %h exp 0", rd[31:0]); end
        idle();
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        checks++; if (rd[31:0] !== 32'h0) begin errors++; $display("FAIL rst_post_reg1: got %h exp 0", rd[31:0]); end
        checks++; if (rd2[31:0] !== 32'h0) begin errors++; $display("FAIL rst_post_reg1_b0: got %h exp 0", rd2[31:0]); end
    endtask

    task automatic test_write_read();
        @(negedge clk);
        idle(); we_a = 1'b1; wa_a = 5'd5; wd_a = 32'hDEADBEEF;
        set_ra(5'd0, 5'd0, 5'd0);
        @(negedge clk);
        idle(); set_ra(5'd5, 5'd0, 5'd0);
        #1;
        checks++; if (rd[31:0] !== 32'hDEADBEEF) begin errors++; $display("FAIL wr_rd0: got %h exp deadbeef", rd[31:0]); end
        checks++; if (rd_busy[0] !== 1'b0) begin errors++; $display("FAIL wr_busy0: got %b exp 0", rd_busy[0]); end
        checks++; if (rd[95:32] !== 64'h0) begin errors++; $display("FAIL wr_rd12_x0: got %h exp 0", rd[95:32]); end
        checks++; if (rd2[31:0] !== 32'hDEADBEEF) begin errors++; $display("FAIL wr_rd0_b0: got %h exp deadbeef", rd2[31:0]); end
    endtask

    task automatic test_bypass();
        @(negedge clk);
        idle(); we_b = 1'b1; wa_b = 5'd7; wd_b = 32'h12345678;
        set_ra(5'd0, 5'd7, 5'd0);
        #1;
        checks++; if (rd[63:32] !== 32'h12345678) begin errors++; $display("FAIL byp_rd1: got %h exp 12345678", rd[63:32]); end
        checks++; if (rd2[63:32] !== 32'h0) begin errors++; $display("FAIL nobyp_rd1: got %h exp 0", rd2[63:32]); end
        @(negedge clk);
        idle();
        #1;
        checks++; if (rd2[63:32] !== 32'h12345678) begin errors++; $display("FAIL nobyp_rd1_after: got %h exp 12345678", rd2[63:32]); end
    endtask

    task automatic test_collision();
        @(negedge clk);
        idle();
        we_a = 1'b1; wa_a = 5'd9; wd_a = 32'h1;
        we_b = 1'b1; wa_b = 5'd9; wd_b = 32'h2;
        set_ra(5'd9, 5'd0, 5'd0);
        #1;
        checks++; if (rd[31:0] !== 32'h2) begin errors++; $display("FAIL col_byp: got %h exp 2", rd[31:0]); end
        @(negedge clk);
        idle();
        #1;
        checks++; if (rd[31:0] !== 32'h2) begin errors++; $display("FAIL col_rd: got %h exp 2", rd[31:0]); end
        checks++; if (rd2[31:0] !== 32'h2) begin errors++; $display("FAIL col_rd_b0: got %h exp 2", rd2[31:0]); end
    endtask

    task automatic test_zero_reg();
        @(negedge clk);
        idle();
        we_a = 1'b1; wa_a = 5'd0; wd_a = 32'hFFFFFFFF;
        rsv_en = 1'b1; rsv_addr = 5'd0;
        set_ra(5'd0, 5'd0, 5'd0);
        #1;
        checks++; if (rd !== 96'h0) begin errors++; $display("FAIL x0_byp: got %h exp 0", rd); end
        checks++; if (rd_busy !== 3'b000) begin errors++; $display("FAIL x0_busy_byp: got %b exp 000", rd_busy); end
        @(negedge clk);
        idle();
        #1;
        checks++; if (rd !== 96'h0) begin errors++; $display("FAIL x0_rd: got %h exp 0", rd); end
        checks++; if (rd_busy2 !== 3'b000) begin errors++; $display("FAIL x0_busy_b0: got %b exp 000", rd_busy2); end
    endtask

    task automatic test_scoreboard();
        @(negedge clk);
        idle(); rsv_en = 1'b1; rsv_addr = 5'd3;
        set_ra(5'd3, 5'd0, 5'd0);
        #1;
        checks++; if (rd_busy[0] !== 1'b0) begin errors++; $display("FAIL rsv_same_cycle: got %b exp 0", rd_busy[0]); end
        @(negedge clk);
        idle();
        #1;
        checks++; if (rd_busy[0] !== 1'b1) begin errors++; $display("FAIL rsv_busy: got %b exp 1", rd_busy[0]); end
        checks++; if (rd_busy2[0] !== 1'b1) begin errors++; $display("FAIL rsv_busy_b0: got %b exp 1", rd_busy2[0]); end
        @(negedge clk);
        idle(); we_a = 1'b1; wa_a = 5'd3; wd_a = 32'h33;
        #1;
        checks++; if (rd_busy[0] !== 1'b0) begin errors++; $display("FAIL wclr_byp_busy: got %b exp 0", rd_busy[0]); end
        checks++; if (rd[31:0] !== 32'h33) begin errors++; $display("FAIL wclr_byp_rd: got %h exp 33", rd[31:0]); end
        checks++; if (rd_busy2[0] !== 1'b1) begin errors++; $display("FAIL wclr_nobyp_busy: got %b exp 1", rd_busy2[0]); end
        checks++; if (rd2[31:0] !== 32'h0) begin errors++; $display("FAIL wclr_nobyp_rd: got %h exp 0", rd2[31:0]); end
        @(negedge clk);
        idle();
        #1;
        checks++; if (rd_busy[0] !== 1'b0) begin errors++; $display("FAIL wclr_busy: got %b exp 0", rd_busy[0]); end
        checks++; if (rd_busy2[0] !== 1'b0) begin errors++; $display("FAIL wclr_busy_b0: got %b exp 0", rd_busy2[0]); end
        checks++; if (rd2[31:0] !== 32'h33) begin errors++; $display("FAIL wclr_rd_b0: got %h exp 33", rd2[31:0]); end
        @(negedge clk);
        idle();
        rsv_en = 1'b1; rsv_addr = 5'd3;
        we_a = 1'b1; wa_a = 5'd3; wd_a = 32'h44;
        @(negedge clk);
        idle();
        #1;
        checks++; if (rd_busy[0] !== 1'b1) begin errors++; $display("FAIL rsvwr_busy: got %b exp 1", rd_busy[0]); end
        checks++; if (rd_busy2[0] !== 1'b1) begin errors++; $display("FAIL rsvwr_busy_b0: got %b exp 1", rd_busy2[0]); end
        checks++; if (rd[31:0] !== 32'h44) begin errors++; $display("FAIL rsvwr_rd: got %h exp 44", rd[31:0]); end
        checks++; if (rd2[31:0] !== 32'h44) begin errors++; $display("FAIL rsvwr_rd_b0: got %h exp 44", rd2[31:0]); end
    endtask

    task automatic test_flush();
        @(negedge clk);
        idle(); rsv_en = 1'b1; rsv_addr = 5'd4;
        @(negedge clk);
        idle(); rsv_en = 1'b1; rsv_addr = 5'd6;
        set_ra(5'd4, 5'd6, 5'd3);
        @(negedge clk);
        idle();
        #1;
        checks++; if (rd_busy !== 3'b111) begin errors++; $display("FAIL fl_pre: got %b exp 111", rd_busy); end
        checks++; if (rd_busy2 !== 3'b111) begin errors++; $display("FAIL fl_pre_b0: got %b exp 111", rd_busy2); end
        @(negedge clk);
        idle(); flush = 1'b1;
        @(negedge clk);
        idle();
        #1;
        checks++; if (rd_busy !== 3'b000) begin errors++; $display("FAIL fl_clear: got %b exp 000", rd_busy); end
        checks++; if (rd_busy2 !== 3'b000) begin errors++; $display("FAIL fl_clear_b0: got %b exp 000", rd_busy2); end
        @(negedge clk);
        idle(); rsv_en = 1'b1; rsv_addr = 5'd6;
        @(negedge clk);
        idle(); flush = 1'b1; rsv_en = 1'b1; rsv_addr = 5'd4;
        @(negedge clk);
        idle();
        #1;
        checks++; if (rd_busy !== 3'b001) begin errors++; $display("FAIL fl_rsv: got %b exp 001", rd_busy); end
        checks++; if (rd_busy2 !== 3'b001) begin errors++; $display("FAIL fl_rsv_b0: got %b exp 001", rd_busy2); end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        idle();
        we_a = 1'b1; wa_a = 5'd10; wd_a = 32'hAA;
        rsv_en = 1'b1; rsv_addr = 5'd11;
        set_ra(5'd10, 5'd11, 5'd5);
        @(negedge clk);
        idle();
        #1;
        checks++; if (rd[31:0] !== 32'hAA) begin errors++; $display("FAIL ar_pre_rd: got %h exp aa", rd[31:0]); end
        checks++; if (rd_busy[1] !== 1'b1) begin errors++; $display("FAIL ar_pre_busy: got %b exp 1", rd_busy[1]); end
        checks++; if (rd[95:64] !== 32'hDEADBEEF) begin errors++; $display("FAIL ar_pre_reg5: got %h exp deadbeef", rd[95:64]); end
        rst_n = 1'b0;
        #1;
        checks++; if (rd !== 96'h0) begin errors++; $display("FAIL ar_rd: got %h exp 0", rd); end
        checks++; if (rd_busy !== 3'b000) begin errors++; $display("FAIL ar_busy: got %b exp 000", rd_busy); end
        checks++; if (rd2 !== 96'h0) begin errors++; $display("FAIL ar_rd_b0: got %h exp 0", rd2); end
        #2;
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        checks++; if (rd !== 96'h0) begin errors++; $display("FAIL ar_post_rd: got %h exp 0", rd); end
        checks++; if (rd_busy !== 3'b000) begin errors++; $display("FAIL ar_post_busy: got %b exp 000", rd_busy); end
        checks++; if (rd_busy2 !== 3'b000) begin errors++; $display("FAIL ar_post_busy_b0: got %b exp 000", rd_busy2); end
    endtask

    task automatic test_out_of_range();
        @(negedge clk);
        idle();
        we_a = 1'b1; wa_a = 5'd20; wd_a = 32'h55;
        rsv_en = 1'b1; rsv_addr = 5'd20;
        set_ra(5'd20, 5'd0, 5'd0);
        #1;
        checks++; if (rd[31:0] !== 32'h55) begin errors++; $display("FAIL oor_byp32: got %h exp 55", rd[31:0]); end
        checks++; if (rd2[31:0] !== 32'h0) begin errors++; $display("FAIL oor_rd16_now: got %h exp 0", rd2[31:0]); end
        @(negedge clk);
        idle();
        #1;
        checks++; if (rd[31:0] !== 32'h55) begin errors++; $display("FAIL oor_rd32: got %h exp 55", rd[31:0]); end
        checks++; if (rd_busy[0] !== 1'b1) begin errors++; $display("FAIL oor_busy32: got %b exp 1", rd_busy[0]); end
        checks++; if (rd2[31:0] !== 32'h0) begin errors++; $display("FAIL oor_rd16: got %h exp 0", rd2[31:0]); end
        checks++; if (rd_busy2[0] !== 1'b0) begin errors++; $display("FAIL oor_busy16: got %b exp 0", rd_busy2[0]); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        ra     = '0;
        idle();
        test_reset();
        test_write_read();
        test_bypass();
        test_collision();
        test_zero_reg();
        test_scoreboard();
        test_flush();
        test_async_reset();
        test_out_of_range();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/register_file_mp.md
Name: register_file_mp

Overview:
Parametrised multi-port integer register file for the pipelined RISC-V core, successor to the single-write/dual-read file.
- Configurable number of read ports, two write ports (ALU/WB and load/late WB) and optional same-cycle write-to-read bypass.
- Per-register busy scoreboard for hazard detection.
- Asynchronous clear of all architectural state.
- Sits between decode (reads, reservations) and writeback (writes, busy clears).

Parameters:
DATA_WIDTH, 32, register width in bits
ADDR_WIDTH, 5, register address width
REG_COUNT, 32, number of implemented registers (2..2^ADDR_WIDTH)
NUM_RD, 3, number of read ports (1..8)
BYPASS, 1, 1 = write data forwarded to same-cycle reads; 0 = reads return pre-write value
ZERO_REG, 1, 1 = register 0 hardwired to zero and never busy

Ports:
CLK  input  1  clock, all state updates on rising edge
RST_N  input  1  asynchronous active-low reset
RA  input  NUM_RD*ADDR_WIDTH  read addresses, port i at bits [i*ADDR_WIDTH +: ADDR_WIDTH]
RD  output  NUM_RD*DATA_WIDTH  read data, port i at bits [i*DATA_WIDTH +: DATA_WIDTH]
RD_BUSY  output  NUM_RD  busy flag of register addressed by port i
WE_A  input  1  write enable, port A
WA_A  input  ADDR_WIDTH  write address, port A
WD_A  input  DATA_WIDTH  write data, port A
WE_B  input  1  write enable, port B (higher priority)
WA_B  input  ADDR_WIDTH  write address, port B
WD_B  input  DATA_WIDTH  write data, port B
RSV_EN  input  1  reserve: set busy bit of RSV_ADDR
RSV_ADDR  input  ADDR_WIDTH  register to reserve
FLUSH  input  1  synchronous clear of all busy bits

Behaviour:
- Reset (RST_N=0, asynchronous): all registers and all busy bits cleared to 0 immediately. RD and RD_BUSY are combinational, so they read all-zero during reset. Writes, reserves and flushes are ignored while RST_N=0.
- Reads: combinational, zero cycles of latency.
  - Address 0 with ZERO_REG=1, or address >= REG_COUNT: RD=0, RD_BUSY=0.
- Writes: committed on the CLK rising edge when WE_x=1.
  - Ignored for address 0 (ZERO_REG=1) or address >= REG_COUNT.
  - WE_A and WE_B to the same address in the same cycle: WD_B is stored and WD_A is dropped.
- Bypass, BYPASS=1: when a read address matches a valid write this cycle, RD returns the write data, with B taking precedence over A, and RD_BUSY returns 0 for that port.
- Bypass, BYPASS=0: RD returns the stored value and RD_BUSY returns the stored busy bit, unaffected by same-cycle writes.
- Scoreboard, evaluated each rising edge in this order:
  1. FLUSH=1 clears all busy bits.
  2. A valid write (A or B) clears the busy bit of its address.
  3. RSV_EN=1 sets the busy bit of RSV_ADDR. The reservation wins over a same-cycle write clear at the same address (a new producer replaces the old one) and over FLUSH.
- RSV_ADDR of 0 (ZERO_REG=1) or >= REG_COUNT: ignored.
- Writing a non-busy register is legal. It updates data and leaves the busy bit at 0.
- Reset asserted mid-cycle or mid-sequence: state clears immediately. The first edge after RST_N deasserts behaves as if from a fresh reset.
- No X propagation: with unimplemented ports unused, every output is a defined value after reset.

Test Plan:
- Reset, then WE_A=1 WA_A=5 WD_A=0xDEADBEEF; next cycle RA port0=5 -> RD0=0xDEADBEEF, RD_BUSY0=0. Ports 1 and 2 at address 0 -> 0.
- BYPASS=1: WE_B=1 WA_B=7 WD_B=0x12345678 with RA port1=7 in the same cycle -> RD1=0x12345678 before the edge. BYPASS=0 build -> RD1=0 (old value) until after the edge.
- Write collision: WE_A=WE_B=1, WA_A=WA_B=9, WD_A=0x1, WD_B=0x2 -> reg9 reads 0x2 next cycle. Write to x0 with 0xFFFFFFFF -> x0 still reads 0 and RD_BUSY=0.
- Scoreboard sequence:
  - RSV_EN=1 RSV_ADDR=3 -> RD_BUSY=1 for reads of 3 the next cycle.
  - WE_A=1 WA_A=3 -> busy cleared after the edge (bypass build: cleared combinationally in the write cycle).
  - Same-cycle RSV_EN and WE_A on reg 3 -> busy=1 afterwards, data updated.
- FLUSH with reg 4 and reg 6 busy -> both clear. FLUSH with RSV_EN at reg 4 in the same cycle -> only reg 4 busy afterwards.
- Write reg 10=0xAA and reserve reg 11, then pulse RST_N low for 3 ns between edges -> RD=0 and RD_BUSY=0 immediately and remain 0 after release. REG_COUNT=16 build: write to address 20 is ignored and reads of 20 return 0.
